wokwi_seven_segment: RTL and testbench



---
 rtl/seg7_pkg.sv | 36 +++
 rtl/seg7_font_rom.sv | 13 +
 rtl/wokwi_seven_segment.sv | 62 ++++++
 tb/tb_wokwi_seven_segment.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment types, constants and the 0-F font.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package seg7_pkg;

    // Segment pattern, a is the MSB, g the LSB; 1 = lit.
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_DARK = 7'b0000000;
    localparam seg_t SEG_ALL  = 7'b1111111;

    // Hex font: uppercase A, C, E, F and lowercase b, d.
    function automatic seg_t seg7_font(input logic [3:0] nibble);
        seg_t pat;
        case (nibble)
            4'h0: pat = 7'b1111110;
            4'h1: pat = 7'b0110000;
            4'h2: pat = 7'b1101101;
            4'h3: pat = 7'b1111001;
            4'h4: pat = 7'b0110011;
            4'h5: pat = 7'b1011011;
            4'h6: pat = 7'b1011111;
            4'h7: pat = 7'b1110000;
            4'h8: pat = 7'b1111111;
            4'h9: pat = 7'b1111011;
            4'ha: pat = 7'b1110111;
            4'hb: pat = 7'b0011111;
            4'hc: pat = 7'b1001110;
            4'hd: pat = 7'b0111101;
            4'he: pat = 7'b1001111;
            4'hf: pat = 7'b1000111;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_font_rom.sv
// Combinational nibble-to-segment lookup, shareable by multi-digit scanners.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows input.
module seg7_font_rom
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       pattern
);

    assign pattern = seg7_font(nibble);

endmodule

// File: rtl/wokwi_seven_segment.sv
// Registered hex-to-seven-segment decoder with blank and lamp-test overrides.
// Latency: one clock from inputs to segment outputs.
// Backpressure: none; every rising edge loads the current inputs.
module wokwi_seven_segment
    import seg7_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic in0,
    input  logic in1,
    input  logic in2,
    input  logic in3,
    input  logic lamp_test,
    input  logic blank,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic e,
    output logic f,
    output logic g
);

    // Output polarity mask; common-anode boards invert every segment.
    localparam seg_t POL_MASK = {7{ACTIVE_LOW}};

    logic [3:0] nibble;
    seg_t       font_pat;
    seg_t       sel_pat;
    seg_t       seg_q;

    assign nibble = {in3, in2, in1, in0};

    seg7_font_rom u_font (
        .nibble  (nibble),
        .pattern (font_pat)
    );

    // Override priority: blank beats lamp test, lamp test beats the font.
    always_comb begin
        sel_pat = font_pat;
        if (blank) begin
            sel_pat = SEG_DARK;
        end else if (lamp_test) begin
            sel_pat = SEG_ALL;
        end
    end

    // Output register; reset shows a dark display at the board's polarity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= SEG_DARK ^ POL_MASK;
        end else begin
            seg_q <= sel_pat ^ POL_MASK;
        end
    end

    assign {a, b, c, d, e, f, g} = seg_q;

endmodule

// File: tb/tb_wokwi_seven_segment.sv
// Self-checking bench for wokwi_seven_segment, both output polarities.
// Latency: checks every output one clock after its inputs are presented.
// Backpressure: n/a; inputs change every cycle.
module tb_wokwi_seven_segment;

    typedef struct {
        logic [3:0] n;
        logic       lamp;
        logic       blk;
        logic [6:0] exp;
    } vec_t;

    logic clk;
    logic clk_en;
    logic rst;
    logic in0, in1, in2, in3;
    logic lamp_test, blank;
    logic a0, b0, c0, d0, e0, f0, g0;
    logic a1, b1, c1, d1, e1, f1, g1;

    int checks;
    int errors;

    logic [6:0] font_ref [16];
    vec_t       vecs [$];

    wokwi_seven_segment #(.ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .rst(rst),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .lamp_test(lamp_test), .blank(blank),
        .a(a0), .b(b0), .c(c0), .d(d0), .e(e0), .f(f0), .g(g0)
    );

    wokwi_seven_segment #(.ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .rst(rst),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .lamp_test(lamp_test), .blank(blank),
        .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1)
    );

    initial clk = 1'b0;
    always #5 clk = clk_en ? ~clk : clk;

    function automatic logic [6:0] seg_hi();
        return {a0, b0, c0, d0, e0, f0, g0};
    endfunction

    function automatic logic [6:0] seg_lo();
        return {a1, b1, c1, d1, e1, f1, g1};
    endfunction

    // Reference: priority rules straight from the datasheet description.
    function automatic logic [6:0] model(input logic [3:0] n, input logic lamp, input logic blk);
        if (blk)  return 7'b0000000;
        if (lamp) return 7'b1111111;
        return font_ref[n];
    endfunction

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] n, input logic lamp, input logic blk);
        {in3, in2, in1, in0} = n;
        lamp_test = lamp;
        blank     = blk;
    endtask

    // Present inputs, clock once, check both polarities just after the edge.
    task automatic apply(input string name, input logic [3:0] n, input logic lamp,
                         input logic blk, input logic [6:0] exp);
        drive(n, lamp, blk);
        @(posedge clk);
        #1;
        check({name, "_hi"}, seg_hi(), exp);
        check({name, "_lo"}, seg_lo(), ~exp);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        font_ref = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                     7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                     7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                     7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

        clk_en = 1'b0;
        rst    = 1'b0;
        drive(4'h2, 1'b0, 1'b0);

        // Reset with no clock running: dark immediately.
        #3 rst = 1'b1;
        #2;
        check("reset_noclk_hi", seg_hi(), 7'b0000000);
        check("reset_noclk_lo", seg_lo(), 7'b1111111);

        // Release reset between edges; first edge loads N=2.
        #1 rst = 1'b0;
        #1 clk_en = 1'b1;
        apply("first_n2", 4'h2, 1'b0, 1'b0, 7'b1101101);

        // Directed table: digits, sweep, overrides.
        vecs.push_back('{4'h5, 1'b0, 1'b0, 7'b1011011});
        vecs.push_back('{4'h8, 1'b0, 1'b0, 7'b1111111});
        vecs.push_back('{4'he, 1'b0, 1'b0, 7'b1001111});
        vecs.push_back('{4'h0, 1'b0, 1'b0, 7'b1111110});
        vecs.push_back('{4'h1, 1'b0, 1'b0, 7'b0110000});
        vecs.push_back('{4'h2, 1'b0, 1'b0, 7'b1101101});
        vecs.push_back('{4'h3, 1'b0, 1'b0, 7'b1111001});
        vecs.push_back('{4'h4, 1'b0, 1'b0, 7'b0110011});
        vecs.push_back('{4'h5, 1'b0, 1'b0, 7'b1011011});
        vecs.push_back('{4'h6, 1'b0, 1'b0, 7'b1011111});
        vecs.push_back('{4'h7, 1'b0, 1'b0, 7'b1110000});
        vecs.push_back('{4'h8, 1'b0, 1'b0, 7'b1111111});
        vecs.push_back('{4'h9, 1'b0, 1'b0, 7'b1111011});
        vecs.push_back('{4'ha, 1'b0, 1'b0, 7'b1110111});
        vecs.push_back('{4'hb, 1'b0, 1'b0, 7'b0011111});
        vecs.push_back('{4'hc, 1'b0, 1'b0, 7'b1001110});
        vecs.push_back('{4'hd, 1'b0, 1'b0, 7'b0111101});
        vecs.push_back('{4'he, 1'b0, 1'b0, 7'b1001111});
        vecs.push_back('{4'hf, 1'b0, 1'b0, 7'b1000111});
        vecs.push_back('{4'h1, 1'b1, 1'b0, 7'b1111111});
        vecs.push_back('{4'h1, 1'b1, 1'b1, 7'b0000000});
        vecs.push_back('{4'h1, 1'b0, 1'b1, 7'b0000000});
        vecs.push_back('{4'h1, 1'b0, 1'b0, 7'b0110000});
        vecs.push_back('{4'h2, 1'b0, 1'b0, 7'b1101101});
        vecs.push_back('{4'h8, 1'b0, 1'b0, 7'b1111111});

        for (int i = 0; i < vecs.size(); i++) begin
            apply($sformatf("vec%0d_n%h_lt%b_bl%b", i, vecs[i].n, vecs[i].lamp, vecs[i].blk),
                  vecs[i].n, vecs[i].lamp, vecs[i].blk, vecs[i].exp);
        end

        // Async reset mid-stream while E is shown; dark before next edge.
        apply("pre_rst_e", 4'he, 1'b0, 1'b0, 7'b1001111);
        #2 rst = 1'b1;
        #1;
        check("midrst_hi", seg_hi(), 7'b0000000);
        check("midrst_lo", seg_lo(), 7'b1111111);
        @(posedge clk);
        #1;
        check("midrst_hold_hi", seg_hi(), 7'b0000000);
        @(negedge clk);
        rst = 1'b0;
        apply("post_rst_e", 4'he, 1'b0, 1'b0, 7'b1001111);

        // Randomised stimulus against the reference model.
        for (int i = 0; i < 300; i++) begin
            logic [3:0] rn;
            logic       rl, rb;
            rn = 4'($urandom_range(15, 0));
            rl = ($urandom_range(3, 0) == 0);
            rb = ($urandom_range(5, 0) == 0);
            apply($sformatf("rnd%0d_n%h_lt%b_bl%b", i, rn, rl, rb), rn, rl, rb, model(rn, rl, rb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
